// File: rtl/controlador_reposicao_rolhas.sv
// Cork-stock refill controller: dispenses corks on capper request and refills
// from the cork feeder over a 4-phase req/ack handshake with a timeout fault.
module controlador_reposicao_rolhas #(
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned MIN_LEVEL = 5,
  parameter int unsigned BATCH     = 15,
  parameter int unsigned MAX_LEVEL = 99,
  parameter int unsigned TIMEOUT   = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  input  logic             consume,
  input  logic             feeder_ack,
  input  logic             fault_clr,
  output logic             feeder_req,
  output logic             consume_ok,
  output logic             consume_deny,
  output logic [WIDTH-1:0] stock,
  output logic             min_signal,
  output logic             refilling,
  output logic             fault
);

  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_RELEASE, FAULT_ST} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] stock_q, stock_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             fault_q, fault_d;
  logic             ok_q, ok_d;
  logic             deny_q, deny_d;

  logic             batch_add;
  logic [SW-1:0]    sum;
  logic [WIDTH-1:0] load_sat;

  assign min_signal = (stock_q <= WIDTH'(MIN_LEVEL));

  always_comb begin
    batch_add = (state_q == REQUEST) && feeder_ack;
    // Acceptance is judged on the pre-update stock; a load cycle swallows the consume.
    ok_d      = consume && !load_en && (stock_q != '0);
    deny_d    = consume && !load_en && (stock_q == '0);
    sum       = {1'b0, stock_q} + (batch_add ? SW'(BATCH) : '0) - (ok_d ? SW'(1) : '0);
    load_sat  = (load_value > WIDTH'(MAX_LEVEL)) ? WIDTH'(MAX_LEVEL) : load_value;

    if (load_en)
      stock_d = load_sat;
    else if (sum > SW'(MAX_LEVEL))
      stock_d = WIDTH'(MAX_LEVEL);
    else
      stock_d = sum[WIDTH-1:0];

    state_d = state_q;
    req_d   = req_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (min_signal && !fault_q) begin
          state_d = REQUEST;
          req_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      REQUEST: begin
        cnt_d = cnt_q + CW'(1);
        if (feeder_ack) begin
          state_d = WAIT_RELEASE;
          req_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = FAULT_ST;
          req_d   = 1'b0;
          fault_d = 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (!feeder_ack) state_d = IDLE;
      end
      FAULT_ST: begin
        req_d = 1'b0;
        if (fault_clr) begin
          state_d = IDLE;
          fault_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stock_q <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      ok_q    <= 1'b0;
      deny_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stock_q <= stock_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      fault_q <= fault_d;
      ok_q    <= ok_d;
      deny_q  <= deny_d;
    end
  end

  assign feeder_req   = req_q;
  assign consume_ok   = ok_q;
  assign consume_deny = deny_q;
  assign stock        = stock_q;
  assign fault        = fault_q;
  assign refilling    = (state_q == REQUEST) || (state_q == WAIT_RELEASE);

endmodule

// File: tb/tb_controlador_reposicao_rolhas.sv
// Bench for controlador_reposicao_rolhas: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model of the stock rules.
module tb_controlador_reposicao_rolhas;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en;
  logic [6:0] load_value;
  logic       consume;
  logic       feeder_ack;
  logic       fault_clr;
  logic       feeder_req;
  logic       consume_ok;
  logic       consume_deny;
  logic [6:0] stock;
  logic       min_signal;
  logic       refilling;
  logic       fault;

  int total = 0;
  int bad   = 0;

  // Reference model: stock as plain integer, handshake as "request up",
  // "waiting for ack release" and "faulted" flags.
  int ms, mcnt;
  bit mreq, mrel, mfault, mok, mdeny;

  controlador_reposicao_rolhas #(
    .WIDTH(7), .MIN_LEVEL(5), .BATCH(15), .MAX_LEVEL(99), .TIMEOUT(200)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_value(load_value),
    .consume(consume), .feeder_ack(feeder_ack), .fault_clr(fault_clr),
    .feeder_req(feeder_req), .consume_ok(consume_ok), .consume_deny(consume_deny),
    .stock(stock), .min_signal(min_signal), .refilling(refilling), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("stock", {1'b0, stock}, 8'(ms));
    chk("feeder_req", {7'b0, feeder_req}, {7'b0, mreq});
    chk("consume_ok", {7'b0, consume_ok}, {7'b0, mok});
    chk("consume_deny", {7'b0, consume_deny}, {7'b0, mdeny});
    chk("fault", {7'b0, fault}, {7'b0, mfault});
    chk("min_signal", {7'b0, min_signal}, {7'b0, ms <= 5});
    chk("refilling", {7'b0, refilling}, {7'b0, mreq | mrel});
  endtask

  function automatic void reset_model();
    ms = 0; mcnt = 0; mreq = 0; mrel = 0; mfault = 0; mok = 0; mdeny = 0;
  endfunction

  task automatic tick();
    int  ns, ncnt, add;
    bit  nreq, nrel, nfault, nok, ndeny, low;
    low    = (ms <= 5);
    nok    = consume && !load_en && ms > 0;
    ndeny  = consume && !load_en && ms == 0;
    add    = (mreq && feeder_ack) ? 15 : 0;
    if (load_en) ns = (int'(load_value) > 99) ? 99 : int'(load_value);
    else begin
      ns = ms + add - (nok ? 1 : 0);
      if (ns > 99) ns = 99;
    end
    nreq = mreq; nrel = mrel; nfault = mfault; ncnt = mcnt;
    if (mfault) begin
      if (fault_clr) begin nfault = 0; ncnt = 0; end
    end else if (mreq) begin
      ncnt = mcnt + 1;
      if (feeder_ack) begin nreq = 0; nrel = 1; end
      else if (ncnt == 200) begin nreq = 0; nfault = 1; end
    end else if (mrel) begin
      if (!feeder_ack) nrel = 0;
    end else if (low) begin
      nreq = 1; ncnt = 0;
    end
    @(posedge clk);
    #1;
    ms = ns; mcnt = ncnt; mreq = nreq; mrel = nrel; mfault = nfault;
    mok = nok; mdeny = ndeny;
    check_all();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; load_en = 0; load_value = '0; consume = 0; feeder_ack = 0; fault_clr = 0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_all();

    // Reset release, first refill handshake
    rst_n = 1'b1;
    tick();
    chk("req_after_reset", {7'b0, feeder_req}, 8'd1);
    feeder_ack = 1; tick();
    chk("first_batch", {1'b0, stock}, 8'd15);
    tick();
    feeder_ack = 0; tick();
    chk("refill_done", {7'b0, refilling}, 8'd0);
    chk("min_after_refill", {7'b0, min_signal}, 8'd0);

    // Load 6, consume one -> low -> request
    load_en = 1; load_value = 7'd6; tick();
    load_en = 0; consume = 1; tick();
    chk("ok_pulse", {7'b0, consume_ok}, 8'd1);
    chk("stock_5", {1'b0, stock}, 8'd5);
    consume = 0; tick();
    chk("req_low", {7'b0, feeder_req}, 8'd1);

    // Empty stock: three denied consumes while request pending
    load_en = 1; load_value = 7'd0; tick();
    load_en = 0; consume = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("deny_pulse", {7'b0, consume_deny}, 8'd1);
    end
    // Stock 4, consume and ack together
    consume = 0; load_en = 1; load_value = 7'd4; tick();
    load_en = 0; consume = 1; feeder_ack = 1; tick();
    chk("batch_minus_one", {1'b0, stock}, 8'd18);
    chk("ok_with_batch", {7'b0, consume_ok}, 8'd1);
    consume = 0; feeder_ack = 0; tick();

    // Saturation: request from 3, load 90 before ack
    load_en = 1; load_value = 7'd3; tick();
    load_en = 0; tick();
    load_en = 1; load_value = 7'd90; tick();
    load_en = 0; feeder_ack = 1; tick();
    chk("saturate_99", {1'b0, stock}, 8'd99);
    feeder_ack = 0; tick();
    // Batch discarded on a load cycle
    load_en = 1; load_value = 7'd3; tick();
    load_en = 0; tick();
    load_en = 1; load_value = 7'd90; feeder_ack = 1; tick();
    chk("load_beats_batch", {1'b0, stock}, 8'd90);
    load_en = 0; feeder_ack = 0; tick();
    // Oversized load saturates
    load_en = 1; load_value = 7'd120; tick();
    load_en = 0; tick();

    // Timeout fault
    load_en = 1; load_value = 7'd2; tick();
    load_en = 0; tick();
    n = 0;
    while (fault !== 1'b1 && n < 300) begin tick(); n++; end
    chk("timeout_len", 8'(n), 8'd200);
    consume = 1; tick();
    chk("consume_in_fault", {7'b0, consume_ok}, 8'd1);
    consume = 0; feeder_ack = 1; tick();
    feeder_ack = 0; fault_clr = 1; tick();
    chk("fault_cleared", {7'b0, fault}, 8'd0);
    fault_clr = 0; tick();
    chk("req_after_clr", {7'b0, feeder_req}, 8'd1);

    // Asynchronous reset mid-handshake
    rst_n = 1'b0;
    #1;
    reset_model();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      load_en    = ($urandom_range(0, 19) == 0);
      load_value = 7'($urandom_range(0, 127));
      consume    = ($urandom_range(0, 1) == 1);
      feeder_ack = ($urandom_range(0, 2) == 0);
      fault_clr  = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controlador_reposicao_rolhas.md
Name: controlador_reposicao_rolhas

Overview:
- Cork-stock refill controller for the bottling line.
- Holds the 7-bit cork stock count and dispenses one cork per capper request.
- Raises the low-stock indication when stock is at or below MIN_LEVEL (5).
- While low, requests a fixed batch from the cork feeder over a 4-phase req/ack handshake, with a timeout fault when the feeder does not respond.

Parameters:
- WIDTH, 7: stock counter width.
- MIN_LEVEL, 5: low-stock threshold; min_signal is asserted when stock <= MIN_LEVEL.
- BATCH, 15: corks added per completed feeder handshake.
- MAX_LEVEL, 99: stock saturation ceiling.
- TIMEOUT, 200: cycles in REQUEST without ack before a fault is raised.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- load_en, input, 1: synchronous preset of stock.
- load_value, input, WIDTH: preset value.
- consume, input, 1: capper requests one cork (sampled each cycle).
- feeder_ack, input, 1: feeder handshake acknowledge.
- fault_clr, input, 1: clears a sticky fault.
- feeder_req, output, 1: feeder handshake request (registered).
- consume_ok, output, 1: one-cycle pulse; cork dispensed.
- consume_deny, output, 1: one-cycle pulse; stock was empty.
- stock, output, WIDTH: current stock (registered).
- min_signal, output, 1: combinational, stock <= MIN_LEVEL.
- refilling, output, 1: high in REQUEST and WAIT_RELEASE.
- fault, output, 1: sticky feeder-timeout flag.

Behaviour:
- Reset (rst_n low, asynchronous): stock=0, state=IDLE, timeout counter=0.
  - feeder_req=0, consume_ok=0, consume_deny=0, fault=0.
  - min_signal=1, since stock 0 <= 5.
- States:
  - IDLE:
    - Go to REQUEST when min_signal=1 and fault=0.
    - feeder_req rises on the same edge that enters REQUEST.
  - REQUEST:
    - feeder_req=1; the timeout counter increments each cycle.
    - On feeder_ack=1: stock <= min(stock+BATCH, MAX_LEVEL) with net consume applied; feeder_req <= 0; go to WAIT_RELEASE.
    - Counter reaching TIMEOUT with no ack: feeder_req <= 0, fault <= 1, go to FAULT.
  - WAIT_RELEASE:
    - Wait for feeder_ack=0, then go to IDLE.
    - If still low, a new request starts only from IDLE, so there is a minimum 1 idle cycle between handshakes.
  - FAULT:
    - feeder_req=0.
    - On fault_clr=1: fault <= 0, counter <= 0, go to IDLE.
    - Consume continues to operate normally.
- Consume:
  - Accepted when consume=1 and the pre-update stock > 0: stock decrements and consume_ok pulses on the next cycle (1-cycle latency).
  - consume=1 with stock=0: stock is unchanged and consume_deny pulses on the next cycle.
  - consume_ok and consume_deny are never high together.
- Simultaneous batch add and accepted consume in one cycle: stock <= min(stock + BATCH - 1, MAX_LEVEL).
  - Acceptance is judged on the pre-update stock.
- load_en has highest priority for stock:
  - stock <= min(load_value, MAX_LEVEL).
  - A consume that cycle is neither decremented nor pulsed.
  - A batch add that cycle is discarded, but the handshake still advances to WAIT_RELEASE.
  - The FSM is not otherwise affected.
- Arithmetic:
  - Additions are computed at WIDTH+1 bits, then saturated to MAX_LEVEL.
  - Stock never wraps below 0 or above MAX_LEVEL.
- Ack behaviour:
  - feeder_ack high while in IDLE or FAULT is ignored.
  - Ack that is already high when REQUEST is entered completes the handshake in that cycle.
- fault_clr outside the FAULT state has no effect.
- rst_n asserted mid-handshake:
  - Immediately drops feeder_req and returns to IDLE.
  - The feeder must tolerate the abandoned request.

Test Plan:
- Reset release with feeder_ack=0:
  - min_signal=1, stock=0.
  - feeder_req=1 one cycle after reset release.
  - Ack held for 2 cycles, then released: stock=15, min_signal=0, refilling drops one cycle after ack falls.
- load_value=6, then 1 consume:
  - consume_ok pulses, stock=5, min_signal=1.
  - Next edge: feeder_req=1.
- load_value=0, consume held for 3 cycles with no ack:
  - consume_deny pulses 3 times; stock stays 0.
- load_value=90, force a handshake (stock low path via load 3, then load 90 before ack):
  - Ack while 90: batch discarded by load priority only on the load cycle; otherwise stock = 99 (saturated).
- Stock=4 in REQUEST, consume and ack asserted in the same cycle:
  - stock=18, consume_ok=1.
- Never ack:
  - After 200 cycles in REQUEST: feeder_req=0, fault=1, consume still works.
  - fault_clr pulse: fault=0 and a new request is issued because min_signal=1.
